alarm_user_ctrl: RTL and testbench

//  User-side driver for the alarm set/control interfaces consumed by the alarm clock core.

---
 rtl/alarm_user_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alarm_user_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_user_ctrl.sv
// Alarm user controller: turns mode/up/down buttons into HH:MM alarm editing and
// commits an absolute UTC posix alarm time. It also issues unset, off and snooze strobes.
// The producer ends of posix_time_ctrl_if and alarm_ctrl_if are flattened into plain
// ports, named after the interface members.
module alarm_user_ctrl #(
  parameter int          GMT             = 3,
  parameter int unsigned LONG_PRESS_MS   = 1500,
  parameter int unsigned EDIT_TIMEOUT_MS = 10000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        tick_ms_i,
  input  logic [31:0] cur_posix_time_i,
  input  logic [16:0] cur_sec_of_day_i,
  input  logic        alarm_active_i,
  input  logic        btn_mode_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  output logic [31:0] usr_posix_time,
  output logic        usr_posix_time_en,
  output logic        usr_unset_alarm,
  output logic        alarm_off_stb,
  output logic        alarm_snooze_stb,
  output logic [1:0]  edit_state_o,
  output logic [4:0]  edit_hh_o,
  output logic [5:0]  edit_mm_o
);

  localparam int unsigned CntMax = (LONG_PRESS_MS > EDIT_TIMEOUT_MS) ? LONG_PRESS_MS
                                                                     : EDIT_TIMEOUT_MS;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] LongLast    = CntW'(LONG_PRESS_MS - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(EDIT_TIMEOUT_MS - 1);
  // The consumer adds GMT*3600 back, so it is removed here.
  localparam logic [31:0] GmtOff = 32'(GMT * 3600);

  typedef enum logic [2:0] {StIdle, StEditHh, StEditMm, StCalc, StCommit} state_e;

  state_e          state_q, state_d;
  logic            btn_mode_q, btn_up_q, btn_down_q;
  logic [CntW-1:0] cnt_q;
  logic            hold_q;
  logic [4:0]      hh_q, cm_hh_q;
  logic [5:0]      mm_q, cm_mm_q;
  logic [31:0]     usr_time_q;
  logic            unset_q, off_q, snooze_q;

  logic mode_rise, up_rise, down_rise, any_rise;
  logic editing, long_hit, short_rel, timeout_hit, inc, dec;
  logic [16:0] t_sod;
  logic        past;
  logic [31:0] next_time;

  assign mode_rise = btn_mode_i & ~btn_mode_q;
  assign up_rise   = btn_up_i & ~btn_up_q;
  assign down_rise = btn_down_i & ~btn_down_q;
  assign any_rise  = mode_rise | up_rise | down_rise;
  assign inc       = up_rise & ~down_rise;
  assign dec       = down_rise & ~up_rise;
  assign editing   = (state_q == StEditHh) || (state_q == StEditMm);

  // Hold count reaches the long-press threshold on this tick.
  assign long_hit = !alarm_active_i && (state_q == StIdle) && hold_q && btn_mode_i &&
                    tick_ms_i && (cnt_q == LongLast);
  assign short_rel = !alarm_active_i && (state_q == StIdle) && hold_q && !btn_mode_i;
  assign timeout_hit = !alarm_active_i && editing && !any_rise && tick_ms_i &&
                       (cnt_q == TimeoutLast);

  // Next alarm occurrence: today if still ahead, otherwise tomorrow (equal counts as past).
  assign t_sod     = 17'(hh_q) * 17'd3600 + 17'(mm_q) * 17'd60;
  assign past      = (t_sod <= cur_sec_of_day_i);
  assign next_time = cur_posix_time_i - 32'(cur_sec_of_day_i) + 32'(t_sod) +
                     (past ? 32'd86400 : 32'd0) - GmtOff;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic; ringing abandons any edit in progress.
  always_comb begin
    state_d = state_q;
    if (alarm_active_i) begin
      if (state_q != StCommit) state_d = StIdle;
      else                     state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (short_rel) state_d = StEditHh;
        StEditHh: begin
          if (mode_rise)        state_d = StEditMm;
          else if (timeout_hit) state_d = StIdle;
        end
        StEditMm: begin
          if (mode_rise)        state_d = StCalc;
          else if (timeout_hit) state_d = StIdle;
        end
        StCalc:   state_d = StCommit;
        StCommit: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM-decoded outputs.
  always_comb begin
    usr_posix_time_en = (state_q == StCommit);
    edit_state_o      = 2'd0;
    if (state_q == StEditHh) edit_state_o = 2'd1;
    if (state_q == StEditMm) edit_state_o = 2'd2;
  end

  // Button edge history and registered single-cycle strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_mode_q <= 1'b0;
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      unset_q    <= 1'b0;
      off_q      <= 1'b0;
      snooze_q   <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode_i;
      btn_up_q   <= btn_up_i;
      btn_down_q <= btn_down_i;
      unset_q    <= long_hit;
      off_q      <= alarm_active_i & mode_rise;
      snooze_q   <= alarm_active_i & (up_rise | down_rise);
    end
  end

  // Shared ms counter: long-press hold time in idle, inactivity time while editing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else if (alarm_active_i) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (mode_rise) begin
        cnt_q  <= '0;
        hold_q <= 1'b1;
      end else if (hold_q) begin
        if (!btn_mode_i || long_hit) begin
          cnt_q  <= '0;
          hold_q <= 1'b0;
        end else if (tick_ms_i) begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end else if (editing) begin
      if (any_rise || timeout_hit) cnt_q <= '0;
      else if (tick_ms_i)          cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Working HH:MM: loaded from the committed value on edit entry, stepped with wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hh_q <= '0;
      mm_q <= '0;
    end else if (short_rel) begin
      hh_q <= cm_hh_q;
      mm_q <= cm_mm_q;
    end else if (!alarm_active_i && !mode_rise) begin
      if (state_q == StEditHh) begin
        if (inc)      hh_q <= (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        else if (dec) hh_q <= (hh_q == 5'd0) ? 5'd23 : hh_q - 5'd1;
      end else if (state_q == StEditMm) begin
        if (inc)      mm_q <= (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        else if (dec) mm_q <= (mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1;
      end
    end
  end

  // Commit the computed posix time and remember the committed HH:MM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      usr_time_q <= '0;
      cm_hh_q    <= '0;
      cm_mm_q    <= '0;
    end else if ((state_q == StCalc) && !alarm_active_i) begin
      usr_time_q <= next_time;
      cm_hh_q    <= hh_q;
      cm_mm_q    <= mm_q;
    end
  end

  assign usr_posix_time   = usr_time_q;
  assign usr_unset_alarm  = unset_q;
  assign alarm_off_stb    = off_q;
  assign alarm_snooze_stb = snooze_q;
  assign edit_hh_o        = hh_q;
  assign edit_mm_o        = mm_q;

endmodule

// File: tb/tb_alarm_user_ctrl.sv
// Bench for alarm_user_ctrl: scoreboard of expected strobes/commits, random edit sessions.
module tb_alarm_user_ctrl;
  localparam int GMT = 3;
  localparam logic [3:0] EvEn = 4'b0001, EvUnset = 4'b0010, EvOff = 4'b0100, EvSnooze = 4'b1000;

  logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [31:0] cur = '0;
  logic [16:0] sod = '0;
  logic        alarm = 1'b0, bm = 1'b0, bu = 1'b0, bd = 1'b0;
  logic [31:0] usr_time;
  logic        en, unset, off, snooze;
  logic [1:0]  st;
  logic [4:0]  hh;
  logic [5:0]  mm;

  typedef struct {logic [3:0] kind; logic [31:0] val;} exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0;
  int cm_hh = 0, cm_mm = 0;
  logic [31:0] last_time = '0;

  alarm_user_ctrl #(.GMT(GMT), .LONG_PRESS_MS(1500), .EDIT_TIMEOUT_MS(10000)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tick_ms_i(tick), .cur_posix_time_i(cur),
    .cur_sec_of_day_i(sod), .alarm_active_i(alarm), .btn_mode_i(bm), .btn_up_i(bu),
    .btn_down_i(bd), .usr_posix_time(usr_time), .usr_posix_time_en(en),
    .usr_unset_alarm(unset), .alarm_off_stb(off), .alarm_snooze_stb(snooze),
    .edit_state_o(st), .edit_hh_o(hh), .edit_mm_o(mm)
  );

  always #5 clk = ~clk;

  // Monitor: every observed strobe/commit must match the head of the expectation queue.
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t e;
    obs = {snooze, off, unset, en};
    if (rst_n && obs != 4'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event_unexpected got kind=%b time=%0d want none", obs, usr_time);
      end else begin
        e = exp_q.pop_front();
        if (obs != e.kind || (e.kind == EvEn && usr_time != e.val)) begin
          fails++;
          $display("FAIL event got kind=%b time=%0d want kind=%b time=%0d",
                   obs, usr_time, e.kind, e.val);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  task automatic tap(input bit m, input bit u, input bit d);
    bm = m; bu = u; bd = d; cyc(1);
    bm = 1'b0; bu = 1'b0; bd = 1'b0; cyc(1);
  endtask

  task automatic check(input string name, input longint act, input longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic expect_ev(input logic [3:0] k, input logic [31:0] v);
    exp_t e;
    e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  // Reference: next local occurrence of HH:MM as UTC posix seconds, modulo 2^32.
  function automatic logic [31:0] model_alarm(input int h, input int m,
                                              input logic [31:0] c, input int s);
    longint cl, t, nxt;
    cl  = longint'({32'b0, c});
    t   = h * 3600 + m * 60;
    nxt = cl - s + t + ((t <= s) ? 86400 : 0) - GMT * 3600;
    return nxt[31:0];
  endfunction

  task automatic set_alarm(input int hu, input int hd, input int mu, input int md,
                           input logic [31:0] tcur, input int tsod,
                           input logic [31:0] fixed, input bit use_fixed);
    int nh, nm;
    logic [31:0] want;
    cur = tcur; sod = 17'(tsod);
    tap(1, 0, 0); cyc(1);
    check("enter_state", st, 1);
    check("enter_hh", hh, cm_hh);
    check("enter_mm", mm, cm_mm);
    repeat (hu) tap(0, 1, 0);
    repeat (hd) tap(0, 0, 1);
    nh = (((cm_hh + hu - hd) % 24) + 24) % 24;
    check("edit_hh", hh, nh);
    tap(1, 0, 0);
    check("state_mm", st, 2);
    repeat (mu) tap(0, 1, 0);
    repeat (md) tap(0, 0, 1);
    nm = (((cm_mm + mu - md) % 60) + 60) % 60;
    check("edit_mm", mm, nm);
    want = use_fixed ? fixed : model_alarm(nh, nm, tcur, tsod);
    expect_ev(EvEn, want);
    tap(1, 0, 0); cyc(3);
    check("after_commit_state", st, 0);
    check("after_commit_time", usr_time, want);
    cm_hh = nh; cm_mm = nm; last_time = want;
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    check("rst_state", st, 0);
    check("rst_time", usr_time, 0);
    check("rst_strobes", {snooze, off, unset, en}, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Fixed time base examples.
    set_alarm(7, 0, 30, 0, 32'd1_700_000_000, 36000, 32'd1_700_066_600, 1'b1);
    set_alarm(3, 0, 0, 30, 32'd1_700_000_000, 36000, 32'd1_700_075_600, 1'b1);
    set_alarm(0, 0, 1, 0, 32'd1_700_000_000, 36000, 32'd1_699_989_260, 1'b1);

    // Wrap and priority behaviour, committed 10:01.
    tap(1, 0, 0); cyc(1);
    repeat (10) tap(0, 0, 1);
    check("hh_down_to_0", hh, 0);
    tap(0, 0, 1);  check("hh_0_down_wrap", hh, 23);
    tap(0, 1, 0);  check("hh_23_up_wrap", hh, 0);
    tap(0, 1, 1);  check("hh_up_down_same", hh, 0);
    tap(1, 1, 0);  check("mode_beats_up_state", st, 2);
    check("mode_beats_up_hh", hh, 0);
    repeat (58) tap(0, 1, 0);
    check("mm_up_to_59", mm, 59);
    tap(0, 1, 0);  check("mm_59_up_wrap", mm, 0);
    tap(0, 0, 1);  check("mm_0_down_wrap", mm, 59);
    tap(0, 1, 1);  check("mm_up_down_same", mm, 59);

    // Ringing while editing minutes: snooze, forced idle, then off.
    alarm = 1'b1;
    expect_ev(EvSnooze, '0);
    tap(0, 1, 0); cyc(1);
    check("ring_state_idle", st, 0);
    expect_ev(EvOff, '0);
    tap(1, 0, 0); cyc(2);
    check("ring_off_state", st, 0);
    alarm = 1'b0; cyc(2);
    check("time_held", usr_time, last_time);

    // Long press unsets once, even while still held.
    bm = 1'b1; cyc(2);
    expect_ev(EvUnset, '0);
    tick_n(1500);
    tick_n(20);
    bm = 1'b0; cyc(3);
    check("long_press_state", st, 0);

    // One tick short of long press: edit entry with committed values.
    bm = 1'b1; cyc(2);
    tick_n(1499);
    bm = 1'b0; cyc(2);
    check("short_press_state", st, 1);
    check("short_press_hh", hh, cm_hh);
    check("short_press_mm", mm, cm_mm);

    // Inactivity timeout.
    tick_n(9999);
    check("timeout_minus1_state", st, 1);
    tick_n(1);
    check("timeout_state", st, 0);

    // Randomized edit sessions against the reference model.
    for (int i = 0; i < 6; i++) begin
      set_alarm($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 70),
                $urandom_range(0, 70), $urandom, $urandom_range(0, 86399), '0, 1'b0);
    end

    // Asynchronous reset in the middle of an edit.
    tap(1, 0, 0); cyc(1);
    tap(1, 0, 0);
    check("pre_reset_state", st, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", st, 0);
    check("async_rst_time", usr_time, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
